// File: rtl/sync_tx_pkg.sv
// Shared types and helpers for the single-wire serial transmitter.
// The parity helper is used only when SYNC_TX_PARITY_EN is defined.
package sync_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_serial_tx_if.sv
// Word handshake into the serial transmitter (in_data / in_valid / in_ready).
// The parity feature is selected elsewhere with SYNC_TX_PARITY_EN.
interface sync_serial_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sync_tx_bit_timer.sv
// Per-bit cycle counter; bit_end marks the last clock of each line bit.
// Its behaviour does not depend on SYNC_TX_PARITY_EN.
module sync_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    generate
        if (CLKS_PER_BIT <= 1) begin : g_single
            // Every bit is one clock long, so no counter is needed.
            logic unused_in;
            assign unused_in = ^{clk, rst, clr};
            assign bit_end   = 1'b1;
        end else begin : g_cnt
            localparam int unsigned CW = $clog2(CLKS_PER_BIT);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || clr || bit_end) cnt <= '0;
                else                       cnt <= cnt + CW'(1);
            end

            assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
        end
    endgenerate

endmodule

// File: rtl/sync_serial_tx.sv
// Frame transmitter: start bit, data LSB-first, optional even parity, stop bit.
// Define SYNC_TX_PARITY_EN to insert the parity bit after the data bits.
module sync_serial_tx
    import sync_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    sync_serial_tx_if.slave   in_if,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_e         state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [IW-1:0]     idx, idx_n;
    logic              line_n;
    logic              done_n;
    logic              bit_end;
`ifdef SYNC_TX_PARITY_EN
    logic              par_q, par_n;
`endif

    sync_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .bit_end (bit_end)
    );

    assign in_if.in_ready = (state == IDLE);
    assign tx_busy        = (state != IDLE);

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        done_n  = 1'b0;
`ifdef SYNC_TX_PARITY_EN
        par_n   = par_q;
`endif
        unique case (state)
            IDLE: begin
                if (in_if.in_valid) begin
                    state_n = START;
                    shreg_n = in_if.in_data;
                    idx_n   = '0;
`ifdef SYNC_TX_PARITY_EN
                    par_n   = even_parity(32'(in_if.in_data));
`endif
                end
            end
            START: if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (idx == IW'(DATA_W - 1)) begin
                        idx_n = '0;
`ifdef SYNC_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
`ifdef SYNC_TX_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // The line register is loaded from the next state so tx_out leads by no extra cycle.
        line_n = IDLE_LEVEL;
        unique case (state_n)
            START:   line_n = START_LEVEL;
            DATA:    line_n = shreg_n[0];
`ifdef SYNC_TX_PARITY_EN
            PARITY:  line_n = par_n;
`endif
            default: line_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            tx_out  <= IDLE_LEVEL;
            tx_done <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            idx     <= idx_n;
            tx_out  <= line_n;
            tx_done <= done_n;
`ifdef SYNC_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_sync_serial_tx.sv
// Directed bench for sync_serial_tx with CLKS_PER_BIT=1 and =4 instances.
// Expected frames follow the parity setting chosen by SYNC_TX_PARITY_EN.
module tb_sync_serial_tx;

`ifdef SYNC_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       v;
    logic       sel;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_serial_tx_if #(.DATA_W(8)) if1 ();
    sync_serial_tx_if #(.DATA_W(8)) if4 ();

    assign if1.in_data  = d;
    assign if4.in_data  = d;
    assign if1.in_valid = v && !sel;
    assign if4.in_valid = v && sel;

    logic o1, b1, dn1, o4, b4, dn4;

    sync_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .in_if(if1), .tx_out(o1), .tx_busy(b1), .tx_done(dn1)
    );
    sync_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .in_if(if4), .tx_out(o4), .tx_busy(b4), .tx_done(dn4)
    );

    logic mo, mb, mr, md;
    assign mo = sel ? o4 : o1;
    assign mb = sel ? b4 : b1;
    assign mr = sel ? if4.in_ready : if1.in_ready;
    assign md = sel ? dn4 : dn1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic done_exp);
        chk({tag, " tx_out"}, 32'(mo), 32'd1);
        chk({tag, " in_ready"}, 32'(mr), 32'd1);
        chk({tag, " tx_busy"}, 32'(mb), 32'd0);
        chk({tag, " tx_done"}, 32'(md), 32'(done_exp));
    endtask

    // Called in the first cycle after the accepting edge; returns in the tx_done cycle.
    task automatic frame(input logic [7:0] w, input int cpb, input logic [7:0] alt);
        logic e;
        for (int b = 0; b < 10 + P; b++) begin
            if (b == 0)                 e = 1'b0;
            else if (b <= 8)            e = w[b-1];
            else if (P == 1 && b == 9)  e = ^w;
            else                        e = 1'b1;
            for (int k = 0; k < cpb; k++) begin
                chk($sformatf("w%0h bit%0d tx_out", w, b), 32'(mo), 32'(e));
                chk("frame tx_busy", 32'(mb), 32'd1);
                chk("frame in_ready", 32'(mr), 32'd0);
                chk("frame tx_done", 32'(md), 32'd0);
                if (b == 3 && k == 0) d = alt;
                step();
            end
        end
        chk_idle($sformatf("w%0h end", w), 1'b1);
    endtask

    initial begin
        rst = 1'b1; v = 1'b0; d = 8'h00; sel = 1'b0;

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("in reset", 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("after reset", 1'b0);
        end
        sel = 1'b1;
        chk_idle("after reset x4", 1'b0);
        sel = 1'b0;

        // 0xA5, one clock per bit.
        d = 8'hA5; v = 1'b1;
        chk("ready before A5", 32'(mr), 32'd1);
        step(); v = 1'b0;
        frame(8'hA5, 1, 8'h00);
        step();
        chk_idle("post A5", 1'b0);

        // 0x07: parity bit 1 when parity is built in.
        d = 8'h07; v = 1'b1;
        step(); v = 1'b0;
        frame(8'h07, 1, 8'hFF);
        step();
        chk_idle("post 07", 1'b0);

        // Back-to-back with in_valid held and in_data changed mid-frame.
        d = 8'h3C; v = 1'b1;
        step();
        frame(8'h3C, 1, 8'hC3);
        chk("b2b valid held", 32'(if1.in_valid), 32'd1);
        step(); v = 1'b0;
        frame(8'hC3, 1, 8'h00);
        step();
        chk_idle("post b2b", 1'b0);

        // Reset in cycle 5 of a frame.
        d = 8'h96; v = 1'b1;
        step(); v = 1'b0;
        repeat (4) step();
        chk("pre-reset busy", 32'(mb), 32'd1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk_idle("mid-frame reset", 1'b0);
        step();
        chk_idle("after mid reset", 1'b0);
        d = 8'h5A; v = 1'b1;
        step(); v = 1'b0;
        frame(8'h5A, 1, 8'h11);
        step();
        chk_idle("post 5A", 1'b0);

        // Reset wins over a simultaneous in_valid.
        d = 8'hFF; v = 1'b1; rst = 1'b1;
        step(); rst = 1'b0; v = 1'b0;
        chk_idle("rst+valid", 1'b0);
        step();
        chk_idle("rst+valid next", 1'b0);

        // Four clocks per bit.
        sel = 1'b1;
        d = 8'h01; v = 1'b1;
        step(); v = 1'b0;
        frame(8'h01, 4, 8'h80);
        step();
        chk_idle("post 01 x4", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_serial_tx.md
# sync_serial_tx

Parallel-in, serial-out frame transmitter. It accepts one DATA_W-bit word over a valid/ready handshake and drives it onto a single-wire line as start bit, data LSB-first, optional parity, and stop bit. It holds each bit for CLKS_PER_BIT clocks. It is the launching end of the team's single-wire serial link, whose far end samples the line with plain registers.

## Interface
- DATA_W, 8: payload width in bits, legal range 1..32.
- CLKS_PER_BIT, 1: clocks each line bit is held, legal range 1..65535.
- clk  in  1  single clock; all logic is posedge clk.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- in_data  in  DATA_W  word to send; captured on the handshake.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- tx_out  out  1  serial line; idles high; registered output.
- tx_busy  out  1  a frame is in progress.
- tx_done  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE: tx_out=1, in_ready=1, tx_busy=0.
  - START: tx_out=0.
  - DATA: tx_out=shreg[0]; the register shifts right once per bit.
  - PARITY: present only with SYNC_TX_PARITY_EN.
  - STOP: tx_out=1.
- Transitions:
  - IDLE→START when in_valid && in_ready at a clock edge; in_data is latched into shreg at that edge.
  - START→DATA, DATA→(PARITY|STOP), PARITY→STOP, STOP→IDLE, each after CLKS_PER_BIT cycles in the state.
  - DATA advances after DATA_W bits.
- in_ready = (state==IDLE). It is decoded from the state register, not from in_valid.
- tx_busy = (state!=IDLE).
- Changes on in_data or in_valid after acceptance are ignored until the block returns to IDLE.
- tx_done pulses high for exactly one cycle: the first IDLE cycle after STOP.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0 on every state or bit advance. The bit index counts 0..DATA_W-1.
- When CLKS_PER_BIT=1 the timer is constant; every bit lasts one cycle.
- Reset mid-frame: the frame is abandoned. On the next edge: state=IDLE, tx_out=1, in_ready=1, tx_busy=0, tx_done=0, counters=0. No partial stop bit is sent.
- rst together with in_valid: reset wins and the word is not accepted.

## Timing
- Reset values: tx_out=1, in_ready=1, tx_busy=0, tx_done=0.
- Handshake at edge N: tx_out goes 0 in cycle N+1 (registered, one-cycle latency). tx_busy=1 and in_ready=0 from cycle N+1.
- Frame length F = CLKS_PER_BIT*(DATA_W+2+P), where P=1 if parity is enabled, else 0.
- The stop bit occupies the last CLKS_PER_BIT cycles of the frame. The cycle after it is IDLE, with tx_done=1 and in_ready=1.
- Back-to-back words: the next handshake can occur in that IDLE cycle, at the earliest. This gives a minimum of one idle-high cycle between frames, so the sustained rate is one word per F+1 cycles.

## Configuration
- SYNC_TX_PARITY_EN defined: a PARITY state is inserted after DATA.
  - The parity bit is even parity, the XOR of the latched word, computed at acceptance.
  - F includes the extra bit.
- SYNC_TX_PARITY_EN undefined: the PARITY state, the parity register and the parity logic are absent. DATA goes directly to STOP.

## Structure
- Package sync_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - the even-parity function.
- Sub-module sync_tx_bit_timer: a counter parameterised by CLKS_PER_BIT with inputs clk, rst, clr and output bit_end. It asserts bit_end in the last cycle of each bit.
- The top level holds the FSM, shreg, bit index and output register.

## Test plan
- Reset only: hold rst for 3 cycles, then release → tx_out=1, in_ready=1, tx_busy=0, tx_done=0 throughout.
- DATA_W=8, CLKS_PER_BIT=1, parity off, send 0xA5 → from N+1 tx_out = 0,1,0,1,0,0,1,0,1,1. In cycle N+11, tx_done=1 for one cycle.
- Same settings with SYNC_TX_PARITY_EN, send 0x07 → after the data bits, the parity bit is 1 and then the stop bit is 1. F=11.
- CLKS_PER_BIT=4, send 0x01 → start low for 4 cycles, data bit 0 high for 4 cycles, then 28 low cycles and 4 high stop cycles. tx_busy is high for 40 cycles.
- in_valid held high with 0x3C then 0xC3 → two frames separated by exactly one idle-high cycle. in_data changes mid-frame do not alter the frame.
- Assert rst in cycle 5 of a frame → next cycle tx_out=1, in_ready=1, no tx_done. A new word then sends a full, correct frame.
